// File: rtl/spu_pkg.sv
// Shared SPU types: quadword, register address and the writeback bus that
// every execution pipe drives into the register file.
package spu_pkg;

    localparam int REG_ADDR_W = 7;
    localparam int QUAD_W     = 128;
    localparam int NUM_REGS   = 128;

    typedef logic [0:QUAD_W-1]     quad_t;
    typedef logic [0:REG_ADDR_W-1] reg_addr_t;

    typedef struct packed {
        quad_t     rt;
        reg_addr_t rt_addr;
        logic      reg_write;
    } wb_bus_t;

    function automatic logic wb_hits(input wb_bus_t wb, input reg_addr_t addr);
        return wb.reg_write && (wb.rt_addr == addr);
    endfunction

    function automatic logic wb_collide(input wb_bus_t wb_even, input wb_bus_t wb_odd);
        return wb_even.reg_write && wb_odd.reg_write && (wb_even.rt_addr == wb_odd.rt_addr);
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port of the SPU register file. With REGFILE_BYPASS_EN
// defined, a same-cycle write to the read address is forwarded (odd wins).
module reg_file_rd_port
    import spu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t i_rd_addr,
    input  quad_t     i_stored,
    input  wb_bus_t   i_wb_even,
    input  wb_bus_t   i_wb_odd,
    output quad_t     o_rd_data
);

    quad_t r_rd_data;
    quad_t w_next;

`ifdef REGFILE_BYPASS_EN
    // Odd is checked first so forwarded data always matches what gets stored.
    always_comb begin
        w_next = i_stored;
        if (wb_hits(i_wb_odd, i_rd_addr)) begin
            w_next = i_wb_odd.rt;
        end else if (wb_hits(i_wb_even, i_rd_addr)) begin
            w_next = i_wb_even.rt;
        end
    end
`else
    logic w_unused_bypass;

    assign w_unused_bypass = ^{i_rd_addr, i_wb_even, i_wb_odd};

    always_comb begin
        w_next = i_stored;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_next;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/reg_file_wb.sv
// SPU writeback register file: 128 x 128-bit, one write port per pipe, five
// registered read ports. Optional write-through bypass via REGFILE_BYPASS_EN.
module reg_file_wb #(
    parameter int NUM_REGS = spu_pkg::NUM_REGS,
    parameter int DATA_W   = spu_pkg::QUAD_W,
    parameter int ADDR_W   = spu_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rt_even_wb,
    input  logic [ADDR_W-1:0] rt_addr_even_wb,
    input  logic              reg_write_even_wb,
    input  logic [DATA_W-1:0] rt_odd_wb,
    input  logic [ADDR_W-1:0] rt_addr_odd_wb,
    input  logic              reg_write_odd_wb,
    input  logic [ADDR_W-1:0] ra_even_addr,
    input  logic [ADDR_W-1:0] rb_even_addr,
    input  logic [ADDR_W-1:0] rc_even_addr,
    input  logic [ADDR_W-1:0] ra_odd_addr,
    input  logic [ADDR_W-1:0] rb_odd_addr,
    output logic [DATA_W-1:0] ra_even,
    output logic [DATA_W-1:0] rb_even,
    output logic [DATA_W-1:0] rc_even,
    output logic [DATA_W-1:0] ra_odd,
    output logic [DATA_W-1:0] rb_odd,
    output logic              wb_conflict
);

    import spu_pkg::*;

    localparam int NUM_RD = 5;

    wb_bus_t   w_wb_even;
    wb_bus_t   w_wb_odd;
    reg_addr_t w_rd_addr [NUM_RD];
    quad_t     w_stored  [NUM_RD];
    quad_t     w_rd_data [NUM_RD];

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_wb_conflict;

    assign w_wb_even = '{rt: rt_even_wb, rt_addr: rt_addr_even_wb, reg_write: reg_write_even_wb};
    assign w_wb_odd  = '{rt: rt_odd_wb,  rt_addr: rt_addr_odd_wb,  reg_write: reg_write_odd_wb};

    // Odd is later in program order within an issue pair, so it wins a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_hits(w_wb_odd, reg_addr_t'(i))) begin
                    r_regs[i] <= rt_odd_wb;
                end else if (wb_hits(w_wb_even, reg_addr_t'(i))) begin
                    r_regs[i] <= rt_even_wb;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_conflict <= 1'b0;
        end else begin
            r_wb_conflict <= wb_collide(w_wb_even, w_wb_odd);
        end
    end

    assign w_rd_addr[0] = ra_even_addr;
    assign w_rd_addr[1] = rb_even_addr;
    assign w_rd_addr[2] = rc_even_addr;
    assign w_rd_addr[3] = ra_odd_addr;
    assign w_rd_addr[4] = rb_odd_addr;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign w_stored[k] = r_regs[w_rd_addr[k]];

        reg_file_rd_port u_rd_port (
            .clk       (clk),
            .reset     (reset),
            .i_rd_addr (w_rd_addr[k]),
            .i_stored  (w_stored[k]),
            .i_wb_even (w_wb_even),
            .i_wb_odd  (w_wb_odd),
            .o_rd_data (w_rd_data[k])
        );
    end

    assign ra_even     = w_rd_data[0];
    assign rb_even     = w_rd_data[1];
    assign rc_even     = w_rd_data[2];
    assign ra_odd      = w_rd_data[3];
    assign rb_odd      = w_rd_data[4];
    assign wb_conflict = r_wb_conflict;

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Writeback-side register file for the SPU: the receiving end of the rt_wb / rt_addr_wb / reg_write_wb interface driven by the even and odd execution pipes (Permute and peers).
- 128 x 128-bit registers, one write port per pipe, five read ports (even ra/rb/rc, odd ra/rb) feeding the RF/FWD stage.
- Reads are registered (1-cycle latency).
- Same-cycle write collisions are resolved deterministically and flagged.

Parameters:
- NUM_REGS, 128, number of architectural registers.
- DATA_W, 128, register width in bits (quadword).
- ADDR_W, 7, register address width; NUM_REGS == 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- rt_even_wb  input  DATA_W  even-pipe writeback value.
- rt_addr_even_wb  input  ADDR_W  even-pipe destination register.
- reg_write_even_wb  input  1  even-pipe write enable.
- rt_odd_wb  input  DATA_W  odd-pipe writeback value.
- rt_addr_odd_wb  input  ADDR_W  odd-pipe destination register.
- reg_write_odd_wb  input  1  odd-pipe write enable.
- ra_even_addr, rb_even_addr, rc_even_addr  input  ADDR_W each  even read addresses.
- ra_odd_addr, rb_odd_addr  input  ADDR_W each  odd read addresses.
- ra_even, rb_even, rc_even  output  DATA_W each  even read data, registered.
- ra_odd, rb_odd  output  DATA_W each  odd read data, registered.
- wb_conflict  output  1  registered pulse: both pipes wrote the same address last cycle.

Behaviour:
- Reset (reset==0, async):
  - All NUM_REGS entries clear to 0.
  - All five read outputs clear to 0.
  - wb_conflict clears to 0.
  - Reset asserted mid-operation discards any in-flight write that cycle.
  - First write is accepted on the first posedge after release.
- Write:
  - On posedge, if reg_write_even_wb==1, regs[rt_addr_even_wb] <= rt_even_wb.
  - The odd port behaves identically.
  - Enable low means no state change, regardless of address or data.
- Write collision (both enables high, equal addresses):
  - The odd value is stored; odd is later in program order within an issue pair.
  - wb_conflict=1 on the following cycle only; otherwise wb_conflict=0.
  - Different addresses: both writes commit in the same cycle.
- Read:
  - Each read output <= regs[addr] sampled at posedge.
  - Result is visible 1 cycle after the address is presented.
  - Read addresses are unconditioned: every port reads every cycle, no enable.
- Bypass (with REGFILE_BYPASS_EN, see Optional Feature):
  - If a read address equals a write address being committed in the same cycle, the output captures the incoming write data, not the stale entry.
  - Under a collision, bypass returns the odd data, consistent with storage.
- Register 0 is an ordinary writable register; there is no hardwired zero.
- Addresses are always in range because the width is exact, so there is no wrap or out-of-range case.
- No stall input: upstream hazard logic guarantees reads are issued only when legal. The file never back-pressures.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass per the Behaviour rules; a read in cycle N of a register written in cycle N returns the new value at N+1.
- Undefined: the read returns the pre-write value at N+1; the new value is visible to reads issued at N+1 or later. Upstream RAW stall logic must then cover one extra cycle.

Decomposition:
- Shared package spu_pkg:
  - localparams REG_ADDR_W=7, QUAD_W=128, NUM_REGS=128.
  - typedef quad_t (logic [0:127]).
  - typedef reg_addr_t (logic [0:6]).
  - struct wb_bus_t {quad_t rt; reg_addr_t rt_addr; logic reg_write;} shared with all execution pipes.
- Sub-module reg_file_rd_port:
  - One registered read port with the two-writer bypass/priority mux.
  - Instantiated 5x.
  - The storage array and write logic stay in reg_file_wb.

Test Plan:
- Reset release, then read addresses 0, 5, 127 on all ports -> all outputs 0x0 one cycle later; wb_conflict=0.
- Even write r10=0xDEADBEEF_00000000_00000000_00000001; next cycle ra_even_addr=10 -> ra_even equals that value at the following cycle; other regs remain 0.
- Same cycle: even writes r3=0x11..11, odd writes r3=0x22..22 -> r3 reads 0x22..22; wb_conflict=1 for exactly one cycle.
- Same cycle: write r7=0xAA..AA and read r7 on rb_odd_addr -> rb_odd=0xAA..AA with REGFILE_BYPASS_EN, prior value 0x0 without it.
- reg_write_odd_wb=0 with rt_addr_odd_wb=4, data 0xFF..FF -> r4 remains 0.
- Fill r0..r127 with value=index; assert reset for half a cycle mid-burst -> all reads return 0 immediately; writes after release commit normally.
